// File: rtl/cc_pkg.sv
// Purpose : shared widths, request layout and helpers for the cache-controller
//           address decoder pipeline.
// Contents: default width constants, default request struct, tag-width helper.
package cc_pkg;

   localparam int unsigned CC_ADDR_W   = 32;
   localparam int unsigned CC_OFFSET_W = 6;
   localparam int unsigned CC_INDEX_W  = 9;
   localparam int unsigned CC_ID_W     = 4;
   localparam int unsigned CC_TAG_W    = CC_ADDR_W - CC_INDEX_W - CC_OFFSET_W;

   // Request layout at default widths; modules with overridden widths declare
   // the same field order locally.
   typedef struct packed {
      logic [CC_TAG_W-1:0]    tag;
      logic [CC_INDEX_W-1:0]  index;
      logic [CC_OFFSET_W-1:0] offset;
      logic [CC_ID_W-1:0]     id;
   } cc_req_t;

   // Tag width left over once index and offset are carved out of the address.
   function automatic int unsigned cc_tag_w(input int unsigned addr_w,
                                            input int unsigned index_w,
                                            input int unsigned offset_w);
      return addr_w - index_w - offset_w;
   endfunction

endpackage

// File: rtl/cc_skid_buf.sv
// Purpose : generic 2-entry valid/ready skid buffer (output register + skid).
// Ports   : clk, rst_n (sync, active-low)
//           i_valid/o_ready/i_data   upstream side; o_ready = skid empty
//           o_valid/i_ready/o_data   downstream side, registered
module cc_skid_buf #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data
);

   logic              r_out_vld;
   logic              r_skid_vld;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] r_skid_data;
   logic              w_out_free;

   assign w_out_free = ~r_out_vld | i_ready;
   assign o_ready    = ~r_skid_vld;
   assign o_valid    = r_out_vld;
   assign o_data     = r_out_data;

   // Skid always drains first so ordering stays FIFO; new data only lands in
   // skid when the output register is stuck.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_vld   <= 1'b0;
         r_skid_vld  <= 1'b0;
         r_out_data  <= '0;
         r_skid_data <= '0;
      end else if (w_out_free) begin
         if (r_skid_vld) begin
            r_out_data <= r_skid_data;
            r_out_vld  <= 1'b1;
            r_skid_vld <= 1'b0;
         end else if (i_valid) begin
            r_out_data <= i_data;
            r_out_vld  <= 1'b1;
         end else begin
            r_out_vld  <= 1'b0;
         end
      end else if (i_valid && !r_skid_vld) begin
         r_skid_data <= i_data;
         r_skid_vld  <= 1'b1;
      end
   end

endmodule

// File: rtl/cc_decoder_pipe.sv
// Purpose : registered AXI AR address decoder feeding the cache lookup pipe.
//           Splits address into tag/index/offset, buffers through a 2-entry
//           skid buffer, throttles on downstream almost-full, counts
//           accepted requests and stall cycles (saturating).
// Ports   : clk, rst_n (sync, active-low)
//           inct_ar*      AR request in, inct_arready_o combinational
//           fifo_afull_i  downstream almost-full flags (any one stalls)
//           dec_valid_o/dec_ready_i, tag_o/index_o/offset_o/id_o  decoded out
//           hs_pulse_o    AR handshake, combinational
//           cnt_clr_i, req_cnt_o, stall_cnt_o  performance counters
module cc_decoder_pipe
   import cc_pkg::*;
#(
   parameter int unsigned ADDR_W   = CC_ADDR_W,
   parameter int unsigned OFFSET_W = CC_OFFSET_W,
   parameter int unsigned INDEX_W  = CC_INDEX_W,
   parameter int unsigned ID_W     = CC_ID_W,
   parameter int unsigned NUM_FIFO = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [ADDR_W-1:0]                    inct_araddr_i,
   input  logic [ID_W-1:0]                      inct_arid_i,
   input  logic                                 inct_arvalid_i,
   output logic                                 inct_arready_o,
   input  logic [NUM_FIFO-1:0]                  fifo_afull_i,
   output logic                                 dec_valid_o,
   input  logic                                 dec_ready_i,
   output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]   tag_o,
   output logic [INDEX_W-1:0]                   index_o,
   output logic [OFFSET_W-1:0]                  offset_o,
   output logic [ID_W-1:0]                      id_o,
   output logic                                 hs_pulse_o,
   input  logic                                 cnt_clr_i,
   output logic [CNT_W-1:0]                     req_cnt_o,
   output logic [CNT_W-1:0]                     stall_cnt_o
);

   localparam int unsigned TAG_W = cc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
   localparam int unsigned REQ_W = TAG_W + INDEX_W + OFFSET_W + ID_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INDEX_W-1:0]  index;
      logic [OFFSET_W-1:0] offset;
      logic [ID_W-1:0]     id;
   } req_t;

   req_t             w_in_req;
   req_t             w_out_req;
   logic [REQ_W-1:0] w_out_data;
   logic             w_afull_any;
   logic             w_skid_free;
   logic             w_hs;
   logic             w_stall;
   logic [CNT_W-1:0] r_req_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   // Accept only with skid room and no downstream pressure; the two already
   // buffered requests are covered by the downstream FIFO thresholds.
   assign w_afull_any    = |fifo_afull_i;
   assign inct_arready_o = rst_n & w_skid_free & ~w_afull_any;
   assign w_hs           = inct_arvalid_i & inct_arready_o;
   assign w_stall        = inct_arvalid_i & ~inct_arready_o;
   assign hs_pulse_o     = w_hs;

   // Address field split.
   assign w_in_req.tag    = inct_araddr_i[ADDR_W-1 -: TAG_W];
   assign w_in_req.index  = inct_araddr_i[INDEX_W+OFFSET_W-1 -: INDEX_W];
   assign w_in_req.offset = inct_araddr_i[OFFSET_W-1:0];
   assign w_in_req.id     = inct_arid_i;

   cc_skid_buf #(
      .DATA_W (REQ_W)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_hs),
      .o_ready (w_skid_free),
      .i_data  (w_in_req),
      .o_valid (dec_valid_o),
      .i_ready (dec_ready_i),
      .o_data  (w_out_data)
   );

   assign w_out_req = req_t'(w_out_data);
   assign tag_o     = w_out_req.tag;
   assign index_o   = w_out_req.index;
   assign offset_o  = w_out_req.offset;
   assign id_o      = w_out_req.id;

   // Saturating performance counters; clear wins over increment.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr_i) begin
         r_req_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_hs && (r_req_cnt != CNT_MAX)) begin
            r_req_cnt <= r_req_cnt + CNT_W'(1);
         end
         if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign req_cnt_o   = r_req_cnt;
   assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_cc_decoder_pipe.sv
// Purpose : self-checking bench for cc_decoder_pipe (CNT_W=4 so saturation is
//           reachable). Reference model: a queue of in-flight requests plus
//           integer counters; fields derived by plain arithmetic.
module tb_cc_decoder_pipe;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned OFFSET_W = 6;
   localparam int unsigned INDEX_W  = 9;
   localparam int unsigned ID_W     = 4;
   localparam int unsigned NUM_FIFO = 4;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned TAG_W    = 17;
   localparam int unsigned CNT_MAX  = 15;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [ADDR_W-1:0]   araddr;
   logic [ID_W-1:0]     arid;
   logic                arvalid;
   logic                arready;
   logic [NUM_FIFO-1:0] afull;
   logic                dec_valid;
   logic                dec_ready;
   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  index;
   logic [OFFSET_W-1:0] offset;
   logic [ID_W-1:0]     id;
   logic                hs_pulse;
   logic                cnt_clr;
   logic [CNT_W-1:0]    req_cnt;
   logic [CNT_W-1:0]    stall_cnt;

   always #5 clk = ~clk;

   cc_decoder_pipe #(
      .ADDR_W   (ADDR_W),
      .OFFSET_W (OFFSET_W),
      .INDEX_W  (INDEX_W),
      .ID_W     (ID_W),
      .NUM_FIFO (NUM_FIFO),
      .CNT_W    (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .inct_araddr_i  (araddr),
      .inct_arid_i    (arid),
      .inct_arvalid_i (arvalid),
      .inct_arready_o (arready),
      .fifo_afull_i   (afull),
      .dec_valid_o    (dec_valid),
      .dec_ready_i    (dec_ready),
      .tag_o          (tag),
      .index_o        (index),
      .offset_o       (offset),
      .id_o           (id),
      .hs_pulse_o     (hs_pulse),
      .cnt_clr_i      (cnt_clr),
      .req_cnt_o      (req_cnt),
      .stall_cnt_o    (stall_cnt)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
   } txn_t;

   txn_t        q[$];
   int unsigned m_req   = 0;
   int unsigned m_stall = 0;

   function automatic logic [TAG_W-1:0] f_tag(input logic [ADDR_W-1:0] a);
      return TAG_W'(a / 32768);
   endfunction
   function automatic logic [INDEX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
      return INDEX_W'((a / 64) % 512);
   endfunction
   function automatic logic [OFFSET_W-1:0] f_offset(input logic [ADDR_W-1:0] a);
      return OFFSET_W'(a % 64);
   endfunction

   // Model: can take a request when fewer than two are held and no flag set.
   function automatic logic m_arready();
      return rst_n && (q.size() < 2) && (afull == '0);
   endfunction

   // Drive all inputs just after the falling edge, then let combinational settle.
   task automatic drive(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] i,
                        input logic v, input logic [NUM_FIFO-1:0] af,
                        input logic rdy, input logic clr);
      araddr    = a;
      arid      = i;
      arvalid   = v;
      afull     = af;
      dec_ready = rdy;
      cnt_clr   = clr;
      #1;
   endtask

   // Advance one clock and update the reference model with the edge's effect.
   task automatic tick();
      logic hs_m, st_m, pop_m, rst_m, clr_m;
      txn_t t;
      hs_m  = arvalid && m_arready();
      st_m  = arvalid && !m_arready();
      pop_m = (q.size() > 0) && dec_ready;
      rst_m = rst_n;
      clr_m = cnt_clr;
      t.addr = araddr;
      t.id   = arid;
      @(posedge clk);
      if (!rst_m) begin
         q.delete();
         m_req   = 0;
         m_stall = 0;
      end else begin
         if (pop_m) void'(q.pop_front());
         if (hs_m) q.push_back(t);
         if (clr_m) begin
            m_req   = 0;
            m_stall = 0;
         end else begin
            if (hs_m && m_req < CNT_MAX) m_req++;
            if (st_m && m_stall < CNT_MAX) m_stall++;
         end
      end
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) begin
         drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
         tick();
      end
   endtask

   task automatic test_reset();
      drive(32'h1234_5678, 4'h1, 1'b1, '0, 1'b1, 1'b0);
      checks++;
      if (arready !== 1'b0) begin
         failures++; $display("FAIL reset_arready: got %0b expected 0", arready);
      end
      checks++;
      if (dec_valid !== 1'b0 || tag !== '0 || id !== '0) begin
         failures++; $display("FAIL reset_out: got valid=%0b tag=%0h id=%0h expected 0/0/0", dec_valid, tag, id);
      end
      checks++;
      if (req_cnt !== '0 || stall_cnt !== '0) begin
         failures++; $display("FAIL reset_cnt: got req=%0d stall=%0d expected 0/0", req_cnt, stall_cnt);
      end
      tick();
      rst_n = 1'b1;
      drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (arready !== 1'b1) begin
         failures++; $display("FAIL reset_release_arready: got %0b expected 1", arready);
      end
   endtask

   task automatic test_decode();
      drive(32'hDEAD_BEEF, 4'd3, 1'b1, '0, 1'b1, 1'b0);
      checks++;
      if (hs_pulse !== 1'b1) begin
         failures++; $display("FAIL decode_hs: got %0b expected 1", hs_pulse);
      end
      tick();
      drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (dec_valid !== 1'b1 || tag !== 17'h1BD5B || index !== 9'h0FB ||
          offset !== 6'h2F || id !== 4'd3) begin
         failures++;
         $display("FAIL decode_fields: got v=%0b tag=%0h idx=%0h off=%0h id=%0h expected 1/1bd5b/0fb/2f/3",
                  dec_valid, tag, index, offset, id);
      end
      checks++;
      if (hs_pulse !== 1'b0) begin
         failures++; $display("FAIL decode_hs_width: got %0b expected 0", hs_pulse);
      end
      checks++;
      if (req_cnt !== 4'd1) begin
         failures++; $display("FAIL decode_req_cnt: got %0d expected 1", req_cnt);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         failures++; $display("FAIL decode_drop: got %0b expected 0", dec_valid);
      end
   endtask

   task automatic test_afull();
      logic [ADDR_W-1:0] a;
      a = $urandom;
      drive('0, '0, 1'b0, '0, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(a, 4'h9, 1'b1, 4'b0100, 1'b1, 1'b0);
         checks++;
         if (arready !== 1'b0 || hs_pulse !== 1'b0) begin
            failures++; $display("FAIL afull_block: cycle %0d got arready=%0b hs=%0b expected 0/0", i, arready, hs_pulse);
         end
         tick();
      end
      drive(a, 4'h9, 1'b1, '0, 1'b1, 1'b0);
      checks++;
      if (stall_cnt !== 4'd5) begin
         failures++; $display("FAIL afull_stall_cnt: got %0d expected 5", stall_cnt);
      end
      checks++;
      if (arready !== 1'b1 || hs_pulse !== 1'b1) begin
         failures++; $display("FAIL afull_release: got arready=%0b hs=%0b expected 1/1", arready, hs_pulse);
      end
      tick();
      drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (dec_valid !== 1'b1 || tag !== f_tag(a) || id !== 4'h9) begin
         failures++; $display("FAIL afull_out: got v=%0b tag=%0h id=%0h expected 1/%0h/9", dec_valid, tag, id, f_tag(a));
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      drive(a, 4'hA, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (hs_pulse !== 1'b1) begin
         failures++; $display("FAIL b2b_accept_a: got %0b expected 1", hs_pulse);
      end
      tick();
      drive(b, 4'hB, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (hs_pulse !== 1'b1) begin
         failures++; $display("FAIL b2b_accept_b: got %0b expected 1", hs_pulse);
      end
      tick();
      drive(32'h0, 4'hC, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (arready !== 1'b0 || dec_valid !== 1'b1 || tag !== f_tag(a) || id !== 4'hA) begin
         failures++; $display("FAIL b2b_full: got arready=%0b v=%0b tag=%0h id=%0h expected 0/1/%0h/a",
                              arready, dec_valid, tag, id, f_tag(a));
      end
      tick();
      drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (tag !== f_tag(a) || index !== f_index(a) || offset !== f_offset(a) || id !== 4'hA) begin
         failures++; $display("FAIL b2b_hold_a: got tag=%0h id=%0h expected %0h/a", tag, id, f_tag(a));
      end
      tick();
      drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (dec_valid !== 1'b1 || tag !== f_tag(b) || index !== f_index(b) ||
          offset !== f_offset(b) || id !== 4'hB) begin
         failures++; $display("FAIL b2b_then_b: got v=%0b tag=%0h id=%0h expected 1/%0h/b", dec_valid, tag, id, f_tag(b));
      end
      checks++;
      if (arready !== 1'b1) begin
         failures++; $display("FAIL b2b_arready_back: got %0b expected 1", arready);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_empty: got %0b expected 0", dec_valid);
      end
   endtask

   task automatic test_random();
      int accepted = 0;
      int cycles   = 0;
      logic [ADDR_W-1:0]   a;
      logic [NUM_FIFO-1:0] af;
      while (accepted < 100 && cycles < 3000) begin
         a  = $urandom;
         af = ($urandom_range(0, 3) == 0) ? NUM_FIFO'($urandom) : '0;
         drive(a, ID_W'($urandom), ($urandom_range(0, 3) != 0), af,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
         checks++;
         if (arready !== m_arready() || hs_pulse !== (arvalid && m_arready())) begin
            failures++; $display("FAIL rand_handshake: cyc %0d got arready=%0b hs=%0b expected %0b/%0b",
                                 cycles, arready, hs_pulse, m_arready(), arvalid && m_arready());
         end
         checks++;
         if (dec_valid !== (q.size() > 0)) begin
            failures++; $display("FAIL rand_valid: cyc %0d got %0b expected %0b", cycles, dec_valid, q.size() > 0);
         end else if (q.size() > 0) begin
            checks++;
            if (tag !== f_tag(q[0].addr) || index !== f_index(q[0].addr) ||
                offset !== f_offset(q[0].addr) || id !== q[0].id) begin
               failures++;
               $display("FAIL rand_payload: cyc %0d got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h", cycles,
                        tag, index, offset, id, f_tag(q[0].addr), f_index(q[0].addr), f_offset(q[0].addr), q[0].id);
            end
         end
         checks++;
         if (req_cnt !== CNT_W'(m_req) || stall_cnt !== CNT_W'(m_stall)) begin
            failures++; $display("FAIL rand_counters: cyc %0d got %0d/%0d expected %0d/%0d",
                                 cycles, req_cnt, stall_cnt, m_req, m_stall);
         end
         if (arvalid && m_arready()) accepted++;
         tick();
         cycles++;
      end
      checks++;
      if (accepted < 100) begin
         failures++; $display("FAIL rand_budget: got %0d accepts expected 100", accepted);
      end
      drain();
      checks++;
      if (dec_valid !== 1'b0 || q.size() != 0) begin
         failures++; $display("FAIL rand_drain: got v=%0b model depth=%0d expected 0/0", dec_valid, q.size());
      end
   endtask

   task automatic test_saturate();
      drive('0, '0, 1'b0, '0, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive($urandom, ID_W'(i), 1'b1, '0, 1'b1, 1'b0);
         tick();
      end
      drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (req_cnt !== 4'd15) begin
         failures++; $display("FAIL sat_req_cnt: got %0d expected 15", req_cnt);
      end
      drive($urandom, 4'h5, 1'b1, '0, 1'b1, 1'b1);
      checks++;
      if (hs_pulse !== 1'b1) begin
         failures++; $display("FAIL clr_hs: got %0b expected 1", hs_pulse);
      end
      tick();
      drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (req_cnt !== 4'd0 || dec_valid !== 1'b1 || id !== 4'h5) begin
         failures++; $display("FAIL clr_priority: got cnt=%0d v=%0b id=%0h expected 0/1/5", req_cnt, dec_valid, id);
      end
      drain();
   endtask

   task automatic test_reset_full();
      drive($urandom, 4'h1, 1'b1, '0, 1'b0, 1'b0);
      tick();
      drive($urandom, 4'h2, 1'b1, '0, 1'b0, 1'b0);
      tick();
      drive('0, '0, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (dec_valid !== 1'b1 || arready !== 1'b0) begin
         failures++; $display("FAIL rstfull_pre: got v=%0b arready=%0b expected 1/0", dec_valid, arready);
      end
      rst_n = 1'b0;
      drive('0, '0, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (arready !== 1'b0) begin
         failures++; $display("FAIL rstfull_arready_low: got %0b expected 0", arready);
      end
      tick();
      rst_n = 1'b1;
      drive('0, '0, 1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (dec_valid !== 1'b0 || arready !== 1'b1 || req_cnt !== '0 || stall_cnt !== '0) begin
         failures++; $display("FAIL rstfull_post: got v=%0b arready=%0b req=%0d stall=%0d expected 0/1/0/0",
                              dec_valid, arready, req_cnt, stall_cnt);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         failures++; $display("FAIL rstfull_discard: got %0b expected 0", dec_valid);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      araddr    = '0;
      arid      = '0;
      arvalid   = 1'b0;
      afull     = '0;
      dec_ready = 1'b0;
      cnt_clr   = 1'b0;
      @(negedge clk);
      test_reset();
      test_decode();
      test_afull();
      test_back_to_back();
      test_random();
      test_saturate();
      test_reset_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
